// File: rtl/hs_npu_memory_ordering_if.sv
// Memory-side request/response bundle between the ordering sequencer (master)
// and the NPU AXI4 burst memory interface (slave).
interface hs_npu_memory_ordering_if #(
  parameter int WORDS_PER_REQ = 2
);
  logic                           mem_read_ready_o;
  logic                           mem_write_valid_o;
  logic                           mem_invalidate_o;
  logic [31:0]                    request_address_o;
  logic [WORDS_PER_REQ-1:0][31:0] mem_wdata_o;
  logic [WORDS_PER_REQ-1:0][31:0] mem_rdata_i;
  logic                           mem_valid_i;
  logic                           mem_ready_i;

  modport master (
    output mem_read_ready_o, mem_write_valid_o, mem_invalidate_o,
           request_address_o, mem_wdata_o,
    input  mem_rdata_i, mem_valid_i, mem_ready_i
  );

  modport slave (
    input  mem_read_ready_o, mem_write_valid_o, mem_invalidate_o,
           request_address_o, mem_wdata_o,
    output mem_rdata_i, mem_valid_i, mem_ready_i
  );
endinterface

// File: rtl/hs_npu_memory_ordering.sv
// Job sequencer: splits a job into fixed-size bursts, unpacks reads into a word stream
// and packs the write stream into bursts. HS_NPU_MEMORY_ORDERING_STATS_EN adds request counters.
module hs_npu_memory_ordering #(
  parameter int WORDS_PER_REQ = 2,
  parameter int MAX_REQS      = 256,
  localparam int CW           = $clog2(MAX_REQS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_valid_i,
  output logic          job_ready_o,
  input  logic          job_write_i,
  input  logic [31:0]   job_base_i,
  input  logic [CW-1:0] job_count_i,
  input  logic          job_abort_i,
  output logic          done_o,
  output logic [31:0]   rd_data_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  input  logic [31:0]   wr_data_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  hs_npu_memory_ordering_if.master mem
`ifdef HS_NPU_MEMORY_ORDERING_STATS_EN
  ,
  output logic [31:0]   stat_rd_reqs_o,
  output logic [31:0]   stat_wr_reqs_o
`endif
);

  localparam int          IW     = (WORDS_PER_REQ > 1) ? $clog2(WORDS_PER_REQ) : 1;
  localparam logic [31:0] STRIDE = 32'(WORDS_PER_REQ * 4);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_DRAIN, WR_FILL, WR_REQ, WR_WAIT, DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [31:0]                    addr_q, addr_d;
  logic [CW-1:0]                  rem_q, rem_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [WORDS_PER_REQ-1:0][31:0] buf_q, buf_d;

  logic        job_ready_q, job_ready_d;
  logic        done_q, done_d;
  logic        rd_valid_q, rd_valid_d;
  logic        wr_ready_q, wr_ready_d;
  logic        rd_req_q, rd_req_d;
  logic        wr_req_q, wr_req_d;
  logic [31:0] req_addr_q, req_addr_d;

  logic abort, last_word, last_req;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    abort     = job_abort_i && (state_q != IDLE) && (state_q != DONE);
    last_word = (idx_q == IW'(WORDS_PER_REQ - 1));
    last_req  = (rem_q == CW'(1));

    // Abort wins over any handshake presented in the same cycle.
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (job_valid_i) begin
          addr_d  = job_base_i;
          rem_d   = job_count_i;
          idx_d   = '0;
          if (job_count_i == '0) state_d = DONE;
          else                   state_d = job_write_i ? WR_FILL : RD_REQ;
        end
        RD_REQ: if (mem.mem_valid_i) begin
          buf_d   = mem.mem_rdata_i;
          idx_d   = '0;
          state_d = RD_DRAIN;
        end
        RD_DRAIN: if (rd_ready_i) begin
          if (last_word) begin
            idx_d   = '0;
            rem_d   = rem_q - CW'(1);
            addr_d  = addr_q + STRIDE;
            state_d = last_req ? DONE : RD_REQ;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        WR_FILL: if (wr_valid_i) begin
          buf_d[idx_q] = wr_data_i;
          if (last_word) begin
            idx_d   = '0;
            state_d = WR_REQ;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        // The interface drops ready to show it has taken the burst.
        WR_REQ: if (!mem.mem_ready_i) state_d = WR_WAIT;
        WR_WAIT: if (mem.mem_ready_i) begin
          rem_d   = rem_q - CW'(1);
          addr_d  = addr_q + STRIDE;
          state_d = last_req ? DONE : WR_FILL;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    job_ready_d = (state_d == IDLE);
    done_d      = (state_d == DONE);
    rd_valid_d  = (state_d == RD_DRAIN);
    wr_ready_d  = (state_d == WR_FILL);
    rd_req_d    = (state_d == RD_REQ);
    wr_req_d    = (state_d == WR_REQ);
    req_addr_d  = (rd_req_d || wr_req_d) ? addr_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      job_ready_q <= 1'b1;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      job_ready_q <= job_ready_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      wr_ready_q  <= wr_ready_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      req_addr_q  <= req_addr_d;
    end
  end

  assign job_ready_o           = job_ready_q;
  assign done_o                = done_q;
  assign rd_valid_o            = rd_valid_q;
  assign wr_ready_o            = wr_ready_q;
  assign rd_data_o             = buf_q[idx_q];
  assign mem.mem_read_ready_o  = rd_req_q;
  assign mem.mem_write_valid_o = wr_req_q;
  assign mem.mem_invalidate_o  = abort;
  assign mem.request_address_o = req_addr_q;
  assign mem.mem_wdata_o       = buf_q;

`ifdef HS_NPU_MEMORY_ORDERING_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d;

  // A request counts once its data phase finishes without being abandoned.
  always_comb begin
    stat_rd_d = stat_rd_q + 32'(state_q == RD_REQ  && mem.mem_valid_i && !abort);
    stat_wr_d = stat_wr_q + 32'(state_q == WR_WAIT && mem.mem_ready_i && !abort);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd_reqs_o = stat_rd_q;
  assign stat_wr_reqs_o = stat_wr_q;
`endif

endmodule

// File: tb/tb_hs_npu_memory_ordering.sv
// Scoreboard bench: job stimulus queues expected requests/words, a memory model answers
// the burst handshake, and a monitor compares every DUT event against the queues.
module tb_hs_npu_memory_ordering;
  localparam int W    = 2;
  localparam int MAXR = 256;
  localparam int CW   = $clog2(MAXR + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid_i = 1'b0;
  logic          job_ready_o;
  logic          job_write_i = 1'b0;
  logic [31:0]   job_base_i = '0;
  logic [CW-1:0] job_count_i = '0;
  logic          job_abort_i = 1'b0;
  logic          done_o;
  logic [31:0]   rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i = 1'b1;
  logic [31:0]   wr_data_i = '0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;

  hs_npu_memory_ordering_if #(.WORDS_PER_REQ(W)) mif ();

  hs_npu_memory_ordering #(.WORDS_PER_REQ(W), .MAX_REQS(MAXR)) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_write_i(job_write_i),
    .job_base_i(job_base_i), .job_count_i(job_count_i), .job_abort_i(job_abort_i),
    .done_o(done_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .mem(mif)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [31:0] d1; logic [31:0] d0; } wexp_t;

  logic [31:0] exp_rq[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_src[$];
  wexp_t       exp_wr[$];
  int          exp_done[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Memory contents: each address/word slot holds a distinct, recomputable value.
  function automatic logic [31:0] rd_word(input logic [31:0] a, input int w);
    return (a * 32'h0001_0003) ^ (32'hC3A5_0000 + 32'(w));
  endfunction

  // Memory model: answers reads after a random delay, takes writes by dropping ready.
  bit rd_pend = 0, wr_busy = 0;
  int rd_cnt = 0, wr_cnt = 0;
  initial begin
    mif.mem_valid_i = 1'b0;
    mif.mem_ready_i = 1'b1;
    mif.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mif.mem_valid_i = 1'b0;
      if (rst || !mif.mem_read_ready_o) rd_pend = 0;
      else if (!rd_pend) begin rd_pend = 1; rd_cnt = $urandom_range(0, 3); end
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mif.mem_valid_i = 1'b1;
          for (int w = 0; w < W; w++) mif.mem_rdata_i[w] = rd_word(mif.request_address_o, w);
          rd_pend = 0;
        end else rd_cnt--;
      end
      if (wr_busy) begin
        if (wr_cnt == 0) begin mif.mem_ready_i = 1'b1; wr_busy = 0; end
        else wr_cnt--;
      end else if (mif.mem_write_valid_o && mif.mem_ready_i && !rst) begin
        mif.mem_ready_i = 1'b0;
        wr_cnt  = $urandom_range(0, 2);
        wr_busy = 1;
      end
    end
  end

  // Write stream source.
  bit wr_hs = 0;
  initial forever begin
    @(negedge clk);
    if (wr_hs && wr_src.size() > 0) void'(wr_src.pop_front());
    wr_valid_i = (wr_src.size() > 0) && ($urandom_range(0, 3) != 0);
    wr_data_i  = (wr_src.size() > 0) ? wr_src[0] : 32'h0;
    #2 wr_hs = wr_valid_i && wr_ready_o && !job_abort_i && !rst;
  end

  // Read stream sink.
  initial forever begin
    @(negedge clk);
    case (rd_mode)
      0:       rd_ready_i = 1'b1;
      1:       rd_ready_i = ~rd_ready_i;
      default: rd_ready_i = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: samples just before the rising edge, when inputs and outputs are settled.
  bit prev_rr = 0, prev_wv = 0, prev_rv = 0, prev_stall = 0, acc_pend = 0;
  logic [31:0] prev_data = '0;
  int last_mv = -10, last_rhs = -10, last_whs = -10, acc_kind = 0, k = 0;
  wexp_t we;
  initial forever begin
    @(negedge clk);
    #2;
    cyc++;
    if (rst) begin
      prev_rr = 0; prev_wv = 0; prev_rv = 0; prev_stall = 0; acc_pend = 0;
    end else begin
      if (mif.mem_read_ready_o && mif.mem_write_valid_o) fail("strobe_overlap");
      if (acc_pend) begin
        acc_pend = 0;
        if (acc_kind == 2) begin
          chk("zero_done_lat", done_o, 1);
          chk("zero_no_mem", {mif.mem_read_ready_o, mif.mem_write_valid_o}, 0);
        end else if (acc_kind == 0) chk("rd_strobe_lat", mif.mem_read_ready_o, 1);
        else chk("wr_fill_lat", wr_ready_o, 1);
      end
      if (job_valid_i && job_ready_o) begin
        acc_pend = 1;
        acc_kind = (job_count_i == '0) ? 2 : int'(job_write_i);
      end
      if (mif.mem_read_ready_o && !prev_rr) begin
        if (exp_rq.size() == 0) fail("rd_req_unexpected");
        else chk("rd_req_addr", mif.request_address_o, exp_rq.pop_front());
      end
      if (rd_valid_o && !prev_rv) chk("rd_valid_lat", 64'(cyc - last_mv), 1);
      if (prev_stall) begin
        chk("rd_hold_valid", rd_valid_o, 1);
        chk("rd_hold_data", rd_data_o, prev_data);
      end
      if (rd_valid_o && rd_ready_i && !job_abort_i) begin
        if (exp_rd.size() == 0) fail("rd_word_unexpected");
        else chk("rd_word", rd_data_o, exp_rd.pop_front());
        last_rhs = cyc;
      end
      if (mif.mem_valid_i && mif.mem_read_ready_o && !job_abort_i) last_mv = cyc;
      if (wr_valid_i && wr_ready_o && !job_abort_i) last_whs = cyc;
      if (mif.mem_write_valid_o && !prev_wv) chk("wr_strobe_lat", 64'(cyc - last_whs), 1);
      if (mif.mem_write_valid_o && !mif.mem_ready_i) begin
        if (exp_wr.size() == 0) fail("wr_req_unexpected");
        else begin
          we = exp_wr.pop_front();
          chk("wr_addr", mif.request_address_o, we.a);
          chk("wr_data0", mif.mem_wdata_o[0], we.d0);
          chk("wr_data1", mif.mem_wdata_o[1], we.d1);
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) fail("done_unexpected");
        else begin
          k = exp_done.pop_front();
          if (k == 0) begin
            chk("rd_done_lat", 64'(cyc - last_rhs), 1);
            chk("rd_done_drained", exp_rd.size() + exp_rq.size(), 0);
          end else if (k == 1) chk("wr_done_drained", exp_wr.size(), 0);
        end
      end
      prev_rr    = mif.mem_read_ready_o;
      prev_wv    = mif.mem_write_valid_o;
      prev_rv    = rd_valid_o;
      prev_stall = rd_valid_o && !rd_ready_i && !job_abort_i;
      prev_data  = rd_data_o;
    end
  end

  task automatic start_job(input bit wr, input logic [31:0] base, input int cnt);
    @(negedge clk);
    job_valid_i = 1'b1;
    job_write_i = wr;
    job_base_i  = base;
    job_count_i = CW'(cnt);
    @(negedge clk);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      #3 seen = done_o;
      @(negedge clk);
    end
    if (!seen) fail({nm, "_timeout"});
  endtask

  // Reference: request i of a job targets base + i*stride (mod 2^32).
  task automatic run_job(input bit wr, input logic [31:0] base, input int cnt, input bit fixed);
    logic [31:0] ad, w0, w1;
    for (int i = 0; i < cnt; i++) begin
      ad = base + 32'(4 * W * i);
      if (!wr) begin
        exp_rq.push_back(ad);
        for (int w = 0; w < W; w++) exp_rd.push_back(rd_word(ad, w));
      end else begin
        w0 = fixed ? 32'hD000_0000 + 32'(2 * i)     : $urandom;
        w1 = fixed ? 32'hD000_0000 + 32'(2 * i + 1) : $urandom;
        wr_src.push_back(w0);
        wr_src.push_back(w1);
        exp_wr.push_back('{a: ad, d1: w1, d0: w0});
      end
    end
    exp_done.push_back(cnt == 0 ? 2 : int'(wr));
    start_job(wr, base, cnt);
    wait_done(wr ? "wr_job" : "rd_job");
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_job_ready", job_ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_rd_req", mif.mem_read_ready_o, 0);
    chk("rst_wr_req", mif.mem_write_valid_o, 0);
    chk("rst_inv", mif.mem_invalidate_o, 0);
    chk("rst_addr", mif.request_address_o, 0);

    rd_mode = 0;
    run_job(0, 32'h0000_1000, 3, 0);
    run_job(1, 32'hFFFF_FFF8, 2, 1);
    rd_mode = 1;
    run_job(0, 32'h0000_5000, 3, 0);
    rd_mode = 0;
    run_job(0, 32'h0000_0040, 0, 0);

    // Abort while the first read request is outstanding.
    exp_rq.push_back(32'h0000_2000);
    start_job(0, 32'h0000_2000, 2);
    job_abort_i = 1'b1;
    #3 chk("abort_inv", mif.mem_invalidate_o, 1);
    @(negedge clk);
    job_abort_i = 1'b0;
    #3;
    chk("abort_idle", job_ready_o, 1);
    chk("abort_inv_1cyc", mif.mem_invalidate_o, 0);
    chk("abort_rd_req_off", mif.mem_read_ready_o, 0);
    repeat (6) @(negedge clk);

    // Reset while waiting for write completion.
    wr_src.push_back(32'h1111_0000);
    wr_src.push_back(32'h1111_0001);
    exp_wr.push_back('{a: 32'h0000_4000, d1: 32'h1111_0001, d0: 32'h1111_0000});
    start_job(1, 32'h0000_4000, 2);
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      #3 seen = mif.mem_write_valid_o && !mif.mem_ready_i;
      @(negedge clk);
    end
    chk("rst_wr_reached", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_src.delete();
    #3;
    chk("rst2_job_ready", job_ready_o, 1);
    chk("rst2_wr_ready", wr_ready_o, 0);
    chk("rst2_wr_req", mif.mem_write_valid_o, 0);
    chk("rst2_rd_valid", rd_valid_o, 0);
    chk("rst2_inv", mif.mem_invalidate_o, 0);
    chk("rst2_addr", mif.request_address_o, 0);
    chk("rst2_wdata", mif.mem_wdata_o, 0);
    chk("rst2_done", done_o, 0);
    run_job(0, 32'h0000_3000, 2, 0);

    rd_mode = 2;
    for (int j = 0; j < 14; j++)
      run_job(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4), 0);

    repeat (4) @(negedge clk);
    chk("end_rq_empty", exp_rq.size(), 0);
    chk("end_rd_empty", exp_rd.size(), 0);
    chk("end_wr_empty", exp_wr.size(), 0);
    chk("end_done_empty", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
